// File: rtl/adaptive_binarization.sv
//------------------------------------------------------------------------------
// Module      : adaptive_binarization
// Description : Luminance binariser, manual threshold or previous-frame mean
//               plus offset. Adaptive path is built when BIN_ADAPTIVE_EN is set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adaptive_binarization #(
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 22,
   parameter int THR_INIT   = 64,
   parameter int THR_OFFSET = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ycbcr_vsync,
   input  logic              ycbcr_hsync,
   input  logic              ycbcr_de,
   input  logic [DATA_W-1:0] luminance,
   input  logic [DATA_W-1:0] thr_manual,
   input  logic              mode,
   output logic              post_vsync,
   output logic              post_hsync,
   output logic              post_de,
   output logic              monoc,
   output logic [DATA_W-1:0] thr_cur,
   output logic              thr_valid
);

   logic              r_vs_d;
   logic              r_hs_d;
   logic              r_de_d;
   logic              r_monoc;
   logic [DATA_W-1:0] w_thr_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d  <= 1'b0;
         r_hs_d  <= 1'b0;
         r_de_d  <= 1'b0;
         r_monoc <= 1'b0;
      end else begin
         r_vs_d  <= ycbcr_vsync;
         r_hs_d  <= ycbcr_hsync;
         r_de_d  <= ycbcr_de;
         r_monoc <= (luminance > w_thr_sel);
      end
   end

   assign post_vsync = r_vs_d;
   assign post_hsync = r_hs_d;
   assign post_de    = r_de_d;
   assign monoc      = r_monoc;
   assign thr_cur    = w_thr_sel;

`ifdef BIN_ADAPTIVE_EN
   localparam int SUM_W  = DATA_W + CNT_W;
   localparam int STEP_W = $clog2(SUM_W);
   localparam int EXT_W  = (SUM_W + 2 > 34) ? SUM_W + 2 : 34;
   localparam logic [STEP_W-1:0]       c_last = STEP_W'(SUM_W - 1);
   localparam logic signed [EXT_W-1:0] c_max  = EXT_W'((1 << DATA_W) - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_UPD  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_vs_rise;
   logic [SUM_W-1:0]    r_sum;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_sat;
   logic                r_fb;
   logic [SUM_W-1:0]    r_quo;
   logic [CNT_W-1:0]    r_rem;
   logic [CNT_W-1:0]    r_dvs;
   logic                r_dsat;
   logic [STEP_W-1:0]   r_step;
   logic [DATA_W-1:0]   r_thr_adapt;
   logic                r_thr_valid;
   logic [CNT_W:0]      w_trial;
   logic [CNT_W:0]      w_diff;
   logic signed [EXT_W-1:0] w_ext;
   logic [DATA_W-1:0]   w_thr_upd;

   assign w_vs_rise = ycbcr_vsync & ~r_vs_d;
   assign w_thr_sel = mode ? r_thr_adapt : thr_manual;
   assign thr_valid = r_thr_valid;

   // A pixel on the boundary cycle seeds the new frame's totals.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (w_vs_rise) begin
         r_sum <= ycbcr_de ? SUM_W'(luminance) : '0;
         r_cnt <= ycbcr_de ? CNT_W'(1) : '0;
         r_sat <= 1'b0;
      end else if (ycbcr_de) begin
         if (&r_cnt) begin
            r_sat <= 1'b1;
         end else begin
            r_sum <= r_sum + SUM_W'(luminance);
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign w_trial = {r_rem, r_quo[SUM_W-1]};
   assign w_diff  = w_trial - {1'b0, r_dvs};
   assign w_ext   = $signed({{(EXT_W - SUM_W){1'b0}}, r_quo}) + $signed(EXT_W'(THR_OFFSET));

   always_comb begin
      w_thr_upd = w_ext[DATA_W-1:0];
      if (w_ext[EXT_W-1]) begin
         w_thr_upd = '0;
      end else if (w_ext > c_max) begin
         w_thr_upd = '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Any new boundary aborts the current run; IDLE restarts it one clock later.
   always_comb begin
      w_state_nxt = r_state;
      if (w_vs_rise) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (r_fb && (r_dvs != '0) && !r_dsat) w_state_nxt = S_DIV;
            S_DIV:  if (r_step == c_last) w_state_nxt = S_UPD;
            S_UPD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fb        <= 1'b0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_dvs       <= '0;
         r_dsat      <= 1'b0;
         r_step      <= '0;
         r_thr_adapt <= DATA_W'(THR_INIT);
         r_thr_valid <= 1'b0;
      end else begin
         r_fb <= w_vs_rise;
         if (w_vs_rise) begin
            r_quo  <= r_sum;
            r_rem  <= '0;
            r_dvs  <= r_cnt;
            r_dsat <= r_sat;
            r_step <= '0;
         end else begin
            case (r_state)
               S_IDLE: r_step <= '0;
               S_DIV: begin
                  r_step <= r_step + 1'b1;
                  if (!w_diff[CNT_W]) begin
                     r_rem <= w_diff[CNT_W-1:0];
                     r_quo <= {r_quo[SUM_W-2:0], 1'b1};
                  end else begin
                     r_rem <= w_trial[CNT_W-1:0];
                     r_quo <= {r_quo[SUM_W-2:0], 1'b0};
                  end
               end
               S_UPD: begin
                  r_thr_adapt <= w_thr_upd;
                  r_thr_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
`else
   logic [32:0] w_unused;

   assign w_thr_sel = thr_manual;
   assign thr_valid = 1'b0;
   assign w_unused  = {mode, 32'(CNT_W ^ THR_INIT ^ THR_OFFSET)};
`endif

endmodule

`default_nettype wire

// File: doc/adaptive_binarization.md
# adaptive_binarization

Parametrised successor to the fixed-threshold binariser in the video pipeline. Each pixel's luminance is compared against either a host-supplied threshold or an adaptive threshold equal to the previous frame's mean luminance plus a signed offset. The block sits directly after the YCbCr conversion stage. Its sync outputs are drop-in compatible with the existing post-processing chain.

## Interface
- DATA_W, 8: luminance and threshold width in bits
- CNT_W, 22: pixel-counter width; supports up to 2^CNT_W-1 pixels per frame
- THR_INIT, 64: threshold value at reset and before the first adaptive update
- THR_OFFSET, 0: signed integer added to the frame mean
- clk  input  1  module clock
- rst_n  input  1  asynchronous active-low reset
- ycbcr_vsync  input  1  frame sync, active high
- ycbcr_hsync  input  1  line sync
- ycbcr_de  input  1  pixel valid
- luminance  input  DATA_W  pixel luminance
- thr_manual  input  DATA_W  host threshold, used when mode=0
- mode  input  1  0 = manual threshold, 1 = adaptive threshold
- post_vsync / post_hsync / post_de  output  1 each  input syncs delayed 1 clk
- monoc  output  1  1 = white (luminance > threshold), 0 = black
- thr_cur  output  DATA_W  threshold currently applied
- thr_valid  output  1  1 once at least one adaptive update has completed since reset

## Operation
- Compare path:
  - monoc <= (luminance > thr_sel), registered.
  - The comparison is strict and unsigned.
  - thr_sel = thr_manual when mode=0; thr_sel = thr_adapt when mode=1.
  - The compare happens every clock regardless of de.
- Sync path: vsync, hsync and de each pass through one register stage.
- Accumulation:
  - While ycbcr_de=1, sum += luminance and cnt += 1.
  - sum width is SUM_W = DATA_W+CNT_W, so sum cannot overflow.
  - When cnt reaches 2^CNT_W-1, further pixels are ignored and the frame is flagged sat.
- Frame boundary: a rising edge of ycbcr_vsync, detected against its 1-clk delayed copy.
- At the frame boundary:
  - sum, cnt and sat are copied into the divider.
  - The accumulators are cleared.
  - A pixel with de=1 in that same cycle belongs to the new frame: the accumulators load it instead of clearing to zero.
- FSM states:
  - IDLE: waits for a frame boundary. Goes to DIV if cnt≠0 and sat=0; otherwise stays in IDLE and no update occurs.
  - DIV: restoring divide computing sum/cnt, one quotient bit per clock, exactly SUM_W clocks, quotient truncated. Then goes to UPD.
  - UPD: computes q + THR_OFFSET, saturated to [0, 2^DATA_W-1]. Writes the result to thr_adapt, sets thr_valid=1, returns to IDLE.
- A frame boundary while in DIV or UPD:
  - The in-flight result is discarded.
  - The divider reloads with the new totals and restarts DIV.
  - thr_adapt is unchanged.
- mode may change at any time:
  - The change takes effect on the next compare.
  - Accumulation and division continue in both modes.
- Reset values:
  - All sync outputs and monoc: 0.
  - thr_adapt: THR_INIT.
  - thr_valid: 0.
  - Accumulators: 0.
  - FSM: IDLE.
- Reset asserted mid-division aborts the division; no update is produced.

## Timing
- Pixel latency: 1 clk. monoc aligns with post_de/post_hsync/post_vsync.
- Adaptive update: thr_cur shows the new value exactly SUM_W+2 clocks after the edge that samples the vsync rising transition. A pixel compared on that clock already uses the new value.
- Throughput: 1 pixel/clk, no stalls, no back-pressure.
- The vertical blanking interval must be at least SUM_W+2 clocks for the update to land before the first active pixel. If it is shorter, the update lands mid-frame; this is permitted.
- thr_cur is combinational from mode, thr_manual and thr_adapt.

## Configuration
- BIN_ADAPTIVE_EN defined:
  - Accumulators, divider FSM and thr_adapt are present.
  - Behaviour is as described above.
- BIN_ADAPTIVE_EN undefined:
  - Accumulators, divider and FSM are removed.
  - mode is ignored and thr_sel = thr_manual.
  - thr_valid is tied to 0.
  - Sync outputs, monoc and the 1-clk latency are unchanged.

## Test plan
- Reset: rst_n=0 with random inputs → all outputs 0, thr_cur=64 (mode=1), thr_valid=0.
- Manual mode: mode=0, thr_manual=100.
  - luminance 100 → monoc 0 one clk later; 101 → monoc 1.
  - post_de equals ycbcr_de delayed 1 clk.
- Adaptive update (DATA_W=8, CNT_W=8, THR_OFFSET=0, mode=1):
  - 16-pixel frame with 8 pixels at 40 and 8 at 160, then a vsync rising edge.
  - thr_cur=100 and thr_valid=1 exactly 18 clks after the edge.
- Offset saturation: THR_OFFSET=+50, frame of all 250 → thr_adapt=255. THR_OFFSET=-50, frame of all 20 → thr_adapt=0.
- Boundary cases:
  - Frame with zero de pixels → thr_cur unchanged and FSM stays IDLE.
  - Second vsync rising edge 5 clks into DIV → only the second frame's mean is applied, SUM_W+2 clks after the second edge.
  - rst_n pulsed mid-DIV → thr_cur returns to 64.
- Saturation: CNT_W=4, 20-pixel frame → no update. Next 10-pixel frame with mean 77 → thr_cur=77.
